// File: rtl/spi_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_req_arbiter
//  Description : Two-port round-robin arbiter in front of the display SPI
//                master. Each grant carries one DATA_W word through a
//                start/done handshake. The arbiter aborts a transaction that
//                gets no spi_done within TIMEOUT cycles, and it always
//                inserts a GAP_CYC idle gap between transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_req_arbiter #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    output logic              spi_sel,
    input  logic              spi_busy,
    input  logic              spi_done,
    output logic [1:0]        owner,
    output logic              timeout_err
);

    // Counter widths: the wait counter only has to reach TIMEOUT-1, and the
    // gap counter only has to reach GAP_CYC-1. Neither counter wraps.
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GCNT_W = $clog2(GAP_CYC + 1);

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                rr_ptr;
    logic                rr_ptr_next;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [WCNT_W-1:0]   wait_cnt_next;
    logic [GCNT_W-1:0]   gap_cnt;
    logic [GCNT_W-1:0]   gap_cnt_next;
    logic [DATA_W-1:0]   spi_data_next;
    logic                spi_sel_next;
    logic [1:0]          owner_next;
    logic                ack0_next;
    logic                ack1_next;
    logic                timeout_err_next;
    logic                grant;

    // State and datapath registers; reset drops any transaction without an ack or an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            spi_data    <= '0;
            spi_sel     <= 1'b0;
            owner       <= 2'b00;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            wait_cnt    <= wait_cnt_next;
            gap_cnt     <= gap_cnt_next;
            spi_data    <= spi_data_next;
            spi_sel     <= spi_sel_next;
            owner       <= owner_next;
            ack0        <= ack0_next;
            ack1        <= ack1_next;
            timeout_err <= timeout_err_next;
        end
    end

    // Next-state logic, arbitration, and the combinational start strobe.
    always_comb begin
        state_next       = state;
        rr_ptr_next      = rr_ptr;
        wait_cnt_next    = wait_cnt;
        gap_cnt_next     = gap_cnt;
        spi_data_next    = spi_data;
        spi_sel_next     = spi_sel;
        owner_next       = owner;
        ack0_next        = 1'b0;
        ack1_next        = 1'b0;
        timeout_err_next = 1'b0;
        spi_start        = 1'b0;
        grant            = 1'b0;

        case (state)
            ST_IDLE: begin
                // A lone requester wins outright. The pointer only breaks a
                // tie between the two ports.
                if (req0 || req1) begin
                    grant         = (req0 && req1) ? rr_ptr : req1;
                    spi_sel_next  = grant;
                    spi_data_next = grant ? data1 : data0;
                    owner_next    = grant ? 2'b10 : 2'b01;
                    state_next    = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Hold the strobe off while the engine is still busy. The
                // strobe lasts exactly one cycle because the FSM leaves this
                // state in the same cycle.
                if (!spi_busy) begin
                    spi_start     = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // If spi_done arrives on the terminal-count cycle, the done
                // path wins and the transaction completes normally.
                if (spi_done) begin
                    ack0_next    = ~spi_sel;
                    ack1_next    = spi_sel;
                    rr_ptr_next  = ~spi_sel;
                    owner_next   = 2'b00;
                    gap_cnt_next = '0;
                    state_next   = ST_GAP;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_err_next = 1'b1;
                    rr_ptr_next      = ~spi_sel;
                    owner_next       = 2'b00;
                    gap_cnt_next     = '0;
                    state_next       = ST_GAP;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end

            ST_GAP: begin
                // Requests are ignored here. This gap gives the slave-select
                // deassert time.
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_req_arbiter
//  Description : Scoreboard bench for spi_req_arbiter. The stimulus process
//                queues the expected starts, acks and timeouts. A monitor
//                process pops an entry and compares it whenever the DUT
//                strobes one of these signals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_req_arbiter;

    localparam int DW    = 16;
    localparam int LIMIT = 200;

    localparam int EV_START = 0;
    localparam int EV_ACK0  = 1;
    localparam int EV_ACK1  = 2;
    localparam int EV_TMO   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0;
    logic [DW-1:0] data0;
    logic          ack0;
    logic          req1;
    logic [DW-1:0] data1;
    logic          ack1;
    logic          spi_start;
    logic [DW-1:0] spi_data;
    logic          spi_sel;
    logic          spi_busy;
    logic          spi_done;
    logic [1:0]    owner;
    logic          timeout_err;

    typedef struct {
        int            kind;
        logic          sel;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    spi_req_arbiter #(.DATA_W(DW), .TIMEOUT(64), .GAP_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .data1       (data1),
        .ack1        (ack1),
        .spi_start   (spi_start),
        .spi_data    (spi_data),
        .spi_sel     (spi_sel),
        .spi_busy    (spi_busy),
        .spi_done    (spi_done),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic sel, input logic [DW-1:0] d);
        exp_t e;
        e.kind = kind;
        e.sel  = sel;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_sel", {31'd0, spi_sel}, {31'd0, e.sel});
            chk("event_data", {16'd0, spi_data}, {16'd0, e.data});
            if (kind == EV_START)
                chk("start_owner", {30'd0, owner}, e.sel ? 32'd2 : 32'd1);
        end
    endtask

    // Monitor: on each strobe seen, pop the next expected entry and compare it.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (spi_start)   observe(EV_START);
            if (ack0)        observe(EV_ACK0);
            if (ack1)        observe(EV_ACK1);
            if (timeout_err) observe(EV_TMO);
        end
    end

    function automatic logic sig(input int w);
        case (w)
            EV_START: return spi_start;
            EV_ACK0:  return ack0;
            EV_ACK1:  return ack1;
            default:  return timeout_err;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Return how many cycles pass before strobe w rises. Entry and exit are
    // both at a drive point; on exit we are in the cycle after the strobe.
    task automatic wait_evt(input int w, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen) begin
            @(negedge clk);
            if (sig(w)) begin
                seen = 1'b1;
            end else begin
                n++;
                if (n > LIMIT) begin
                    errors++;
                    $display("FAIL wait_evt_%0d: got no strobe within %0d cycles expected strobe", w, LIMIT);
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $fatal(1, "bounded wait expired");
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Call from the drive point of a WAIT cycle. The task pulses spi_done,
    // checks the ack pulse, and returns at the drive point of the IDLE cycle.
    task automatic finish_txn(input logic p, input logic [DW-1:0] d);
        push(p ? EV_ACK1 : EV_ACK0, p, d);
        spi_done = 1'b1;
        @(posedge clk);
        #1;
        spi_done = 1'b0;
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
        @(negedge clk);
        chk("ack_pulse", {31'd0, (p ? ack1 : ack0)}, 32'd1);
        chk("ack_other", {31'd0, (p ? ack0 : ack1)}, 32'd0);
        chk("owner_after_done", {30'd0, owner}, 32'd0);
        chk("no_timeout_on_done", {31'd0, timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ack_one_cycle", {30'd0, ack0, ack1}, 32'd0);
        chk("no_timeout_gap", {31'd0, timeout_err}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got time limit expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst      = 1'b1;
        req0     = 1'b0;
        req1     = 1'b0;
        data0    = '0;
        data1    = '0;
        spi_busy = 1'b0;
        spi_done = 1'b0;

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_start", {31'd0, spi_start}, 32'd0);
        chk("rst_data", {16'd0, spi_data}, 32'd0);
        chk("rst_sel", {31'd0, spi_sel}, 32'd0);
        chk("rst_acks", {30'd0, ack0, ack1}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);

        // 1: single port-0 word; the start strobe comes one cycle after the request
        @(posedge clk);
        #1;
        rst   = 1'b0;
        req0  = 1'b1;
        data0 = 16'hA5C3;
        push(EV_START, 1'b0, 16'hA5C3);
        wait_evt(EV_START, n);
        chk("t1_start_latency", n, 1);
        data0 = 16'hFFFF;            // must not disturb the latched word
        req1  = 1'b1;                // pending during WAIT; served only after the gap
        data1 = 16'h1234;
        step(19);                    // spi_done 20 cycles after start
        finish_txn(1'b0, 16'hA5C3);
        push(EV_START, 1'b1, 16'h1234);
        wait_evt(EV_START, n);
        chk("t1_gap_two_cycles", n, 1);
        step(4);
        finish_txn(1'b1, 16'h1234);

        // 2: both ports held; grants should alternate 0,1,0,1
        req0  = 1'b1;
        data0 = 16'h0100;
        req1  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic          p;
            logic [DW-1:0] d;
            p = i[0];
            d = p ? 16'h1234 : ((i == 0) ? 16'h0100 : 16'h0101);
            push(EV_START, p, d);
            wait_evt(EV_START, n);
            chk("t2_rr_latency", n, 1);
            step(2);
            finish_txn(p, d);
            case (i)
                0: begin req0 = 1'b1; data0 = 16'h0101; end
                1: req1 = 1'b1;
                2: req0 = 1'b1;
                default: req0 = 1'b0;
            endcase
        end

        // 3: spi_busy keeps the start strobe low for 5 cycles
        push(EV_START, 1'b0, 16'hBEEF);
        spi_busy = 1'b1;
        req0     = 1'b1;
        data0    = 16'hBEEF;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("t3_start_held_busy", {31'd0, spi_start}, 32'd0);
            chk("t3_owner_issue", {30'd0, owner}, 32'd1);
        end
        @(posedge clk);
        #1;
        spi_busy = 1'b0;
        @(negedge clk);
        chk("t3_start_after_busy", {31'd0, spi_start}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_start_single", {31'd0, spi_start}, 32'd0);
        @(posedge clk);
        #1;
        finish_txn(1'b0, 16'hBEEF);

        // 4: timeout on port 0 while port 1 is pending
        req0  = 1'b1;
        data0 = 16'h0F0F;
        push(EV_START, 1'b0, 16'h0F0F);
        wait_evt(EV_START, n);
        chk("t4_start_latency", n, 1);
        req1 = 1'b1;
        push(EV_TMO, 1'b0, 16'h0F0F);
        wait_evt(EV_TMO, n);
        chk("t4_timeout_cycle", n, 64);
        push(EV_START, 1'b1, 16'h1234);
        wait_evt(EV_START, n);
        chk("t4_port1_after_gap", n, 2);
        finish_txn(1'b1, 16'h1234);
        push(EV_START, 1'b0, 16'h0F0F);   // un-acked port 0 is retried
        wait_evt(EV_START, n);
        chk("t4_retry_latency", n, 1);
        finish_txn(1'b0, 16'h0F0F);

        // 5: spi_done on the terminal-count cycle wins over the timeout
        req0  = 1'b1;
        data0 = 16'h7E57;
        push(EV_START, 1'b0, 16'h7E57);
        wait_evt(EV_START, n);
        chk("t5_start_latency", n, 1);
        step(63);
        finish_txn(1'b0, 16'h7E57);

        // 6: reset in WAIT aborts silently; the held request is served again
        req0  = 1'b1;
        data0 = 16'hC0DE;
        push(EV_START, 1'b0, 16'hC0DE);
        wait_evt(EV_START, n);
        chk("t6_start_latency", n, 1);
        step(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_rst_owner", {30'd0, owner}, 32'd0);
        chk("t6_rst_data", {16'd0, spi_data}, 32'd0);
        chk("t6_rst_sel", {31'd0, spi_sel}, 32'd0);
        chk("t6_rst_start", {31'd0, spi_start}, 32'd0);
        chk("t6_rst_flags", {29'd0, ack0, ack1, timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(EV_START, 1'b0, 16'hC0DE);
        wait_evt(EV_START, n);
        chk("t6_regrant_latency", n, 1);
        finish_txn(1'b0, 16'hC0DE);

        step(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
